// File: rtl/filter_green_ctrl.sv
// Streams one frame of RGB pixels through an inclusive per-channel green window
// and hands each packed row mask (0 = green, 1 = not green) to a downstream consumer.
module filter_green_ctrl #(
  parameter int HEIGHT = 28,
  parameter int WIDTH  = 28
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [2:0][7:0]                      lower_green,
  input  logic [2:0][7:0]                      upper_green,
  input  logic                                 pix_valid,
  input  logic [2:0][7:0]                      pix_data,
  output logic                                 pix_ready,
  output logic                                 row_valid,
  input  logic                                 row_ready,
  output logic [WIDTH-1:0]                     row_mask,
  output logic [$clog2(HEIGHT)-1:0]            row_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(HEIGHT*WIDTH+1)-1:0]    green_count
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int GW = $clog2(HEIGHT*WIDTH+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   col;
  logic [2:0][7:0] lo_q;
  logic [2:0][7:0] hi_q;
  logic            is_green;
  logic            accept;
  logic            last_col;
  logic            last_row;

  // A pixel is green only when every channel sits inside the latched window.
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves is_green unassigned (no latch).
    is_green = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (pix_data[k] < lo_q[k] || pix_data[k] > hi_q[k]) is_green = 1'b0;
    end
  end

  assign accept   = pix_valid & pix_ready;
  assign last_col = (col == CW'(WIDTH - 1));
  assign last_row = (row_idx == RW'(HEIGHT - 1));

  // Handshake and status outputs are pure decodes of the state register.
  assign pix_ready = (state == S_RUN);
  assign row_valid = (state == S_FLUSH);
  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: row_mask is a plain flop vector, not a memory, so it is cleared by reset like any other state.
      state       <= S_IDLE;
      col         <= '0;
      row_idx     <= '0;
      row_mask    <= '0;
      green_count <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            lo_q        <= lower_green;
            hi_q        <= upper_green;
            col         <= '0;
            row_idx     <= '0;
            green_count <= '0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            row_mask[col] <= ~is_green;
            if (is_green) green_count <= green_count + GW'(1);
            if (last_col) begin
              col   <= '0;
              state <= S_FLUSH;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (row_ready) begin
            if (last_row) begin
              state <= S_DONE;
            end else begin
              row_idx <= row_idx + RW'(1);
              state   <= S_RUN;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
